// File: rtl/scale_mux_bist.sv
// scale_mux_bist: exhaustive 8-vector self-test engine for the scale_mux; SCALE_MUX_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module scale_mux_bist #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_mux_out,
    output logic [WIDTH-1:0] o_in_a,
    output logic [WIDTH-1:0] o_in_b,
    output logic             o_sel_a,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [3:0]       o_err_cnt,
    output logic             o_fail_valid,
    output logic [2:0]       o_first_fail
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
    state_t     state;
    logic [2:0] vec;
    logic [3:0] settle;
    logic       active;
    logic       mismatch;
    logic       last;
    assign active   = (state == DRIVE) || (state == CHECK);
    assign o_in_a   = active ? {WIDTH{vec[2]}} : '0;
    assign o_in_b   = active ? {WIDTH{vec[1]}} : '0;
    assign o_sel_a  = active & vec[0];
    // case inequality so X/Z from the mux counts as a failure in simulation
    assign mismatch = i_mux_out !== (vec[0] ? {WIDTH{vec[2]}} : {WIDTH{vec[1]}});
`ifdef SCALE_MUX_BIST_STOP_ON_FAIL_EN
    assign last = mismatch || (vec == 3'd7);
`else
    assign last = vec == 3'd7;
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            vec          <= '0;
            settle       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_err_cnt    <= '0;
            o_fail_valid <= 1'b0;
            o_first_fail <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state        <= DRIVE;
                        vec          <= '0;
                        settle       <= '0;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_pass       <= 1'b0;
                        o_err_cnt    <= '0;
                        o_fail_valid <= 1'b0;
                        o_first_fail <= '0;
                    end
                end
                DRIVE: begin
                    settle <= settle + 4'd1;
                    if (settle == 4'(SETTLE_CYCLES - 1))
                        state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        o_err_cnt <= o_err_cnt + 4'd1;
                        if (!o_fail_valid) begin
                            o_fail_valid <= 1'b1;
                            o_first_fail <= vec;
                        end
                    end
                    if (last) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_pass <= !mismatch && (o_err_cnt == 4'd0);
                    end else begin
                        state  <= DRIVE;
                        vec    <= vec + 3'd1;
                        settle <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
